// File: rtl/aes_key_expansion_ctrl.sv
// -----------------------------------------------------------------------------
// aes_key_expansion_ctrl
//
// Sequential AES-128 key expansion. A single shared round-key stage
// (RotWord, SubWord, Rcon, XOR chain) is applied once per round to turn the
// cipher key into round keys 0..10. Each key is streamed on rk_out as it is
// produced and written into an 11-entry table that can be read by index.
//
// Build option:
//   KEYSCHED_SBOX_PIPE_EN  - when defined, registers SubWord(RotWord(w3))^Rcon
//                            in an extra SUB state, so each round takes two
//                            cycles. When undefined, one round per cycle.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   start       request expansion (only honoured when not busy, or on the
//               closing edge of a run for back-to-back operation)
//   key_in      128-bit cipher key, word 0 = [127:96]
//   busy        expansion in progress
//   rk_valid    rk_out/rk_round carry a newly generated round key
//   rk_round    index of the round key on rk_out
//   rk_out      current round key
//   done        one-cycle pulse alongside round 10
//   keys_ready  table holds a complete schedule
//   rd_idx      table read index
//   rd_key      table entry rd_idx, combinational; 0 when rd_idx > 10
// -----------------------------------------------------------------------------
module aes_key_expansion_ctrl #(
    parameter int NROUNDS = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    output logic [3:0]   rk_round,
    output logic [127:0] rk_out,
    output logic         done,
    output logic         keys_ready,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
);

    localparam logic [3:0] LAST_ROUND = 4'(NROUNDS);

`ifdef KEYSCHED_SBOX_PIPE_EN
    typedef enum logic [1:0] {IDLE, EXPAND, SUB} state_t;
    localparam state_t FIRST_STATE = SUB;
`else
    typedef enum logic [1:0] {IDLE, EXPAND} state_t;
    localparam state_t FIRST_STATE = EXPAND;
`endif

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t         state_q;
    logic           busy_q;
    logic           rk_valid_q;
    logic [3:0]     rk_round_q;
    logic [127:0]   rk_out_q;
    logic           done_q;
    logic           keys_ready_q;
    logic [127:0]   rk_table_q [0:NROUNDS];

    logic [3:0]     next_round_d;
    logic [31:0]    t_d;
    logic [31:0]    t_use;
    logic [127:0]   round_key_d;
    logic           accept;

    assign next_round_d = rk_round_q + 4'd1;

    // t depends only on w3 of the current key and the round number, so it
    // is the natural place to cut the path when the S-box is pipelined.
    assign t_d = sub_word({rk_out_q[23:0], rk_out_q[31:24]}) ^ {rcon(next_round_d), 24'h0};

`ifdef KEYSCHED_SBOX_PIPE_EN
    logic [31:0] t_q;
    assign t_use = t_q;
`else
    assign t_use = t_d;
`endif

    always_comb begin
        round_key_d[127:96] = rk_out_q[127:96] ^ t_use;
        round_key_d[95:64]  = rk_out_q[95:64]  ^ round_key_d[127:96];
        round_key_d[63:32]  = rk_out_q[63:32]  ^ round_key_d[95:64];
        round_key_d[31:0]   = rk_out_q[31:0]   ^ round_key_d[63:32];
    end

    // The closing edge of a run (done_q high) doubles as an IDLE sample so
    // back-to-back runs need no dead cycle; every other busy cycle ignores start.
    assign accept = start && ((state_q == IDLE) || done_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            rk_valid_q   <= 1'b0;
            rk_round_q   <= 4'd0;
            rk_out_q     <= '0;
            done_q       <= 1'b0;
            keys_ready_q <= 1'b0;
`ifdef KEYSCHED_SBOX_PIPE_EN
            t_q          <= '0;
`endif
            // NOTE: the table is reset entry by entry because a reset must
            // leave it reading back zero; a RAM macro could not do this.
            for (int i = 0; i <= NROUNDS; i++) begin
                rk_table_q[i] <= '0;
            end
        end else if (accept) begin
            state_q       <= FIRST_STATE;
            busy_q        <= 1'b1;
            rk_valid_q    <= 1'b1;
            rk_round_q    <= 4'd0;
            rk_out_q      <= key_in;
            done_q        <= 1'b0;
            keys_ready_q  <= 1'b0;
            rk_table_q[0] <= key_in;
        end else if (done_q) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            rk_valid_q   <= 1'b0;
            done_q       <= 1'b0;
            keys_ready_q <= 1'b1;
        end else begin
            case (state_q)
                EXPAND: begin
                    rk_out_q                 <= round_key_d;
                    rk_round_q               <= next_round_d;
                    rk_valid_q               <= 1'b1;
                    done_q                   <= (next_round_d == LAST_ROUND);
                    rk_table_q[next_round_d] <= round_key_d;
`ifdef KEYSCHED_SBOX_PIPE_EN
                    state_q                  <= SUB;
`endif
                end
`ifdef KEYSCHED_SBOX_PIPE_EN
                SUB: begin
                    t_q        <= t_d;
                    rk_valid_q <= 1'b0;
                    state_q    <= EXPAND;
                end
`endif
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign rk_valid   = rk_valid_q;
    assign rk_round   = rk_round_q;
    assign rk_out     = rk_out_q;
    assign done       = done_q;
    assign keys_ready = keys_ready_q;
    assign rd_key     = (rd_idx <= LAST_ROUND) ? rk_table_q[rd_idx] : '0;

endmodule

// File: tb/tb_aes_key_expansion_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_key_expansion_ctrl
//
// Directed bench for aes_key_expansion_ctrl. Expected round keys are pushed
// into a scoreboard queue before each start; a monitor pops one entry per
// rk_valid cycle. Timing, table read-back and reset behaviour are checked
// inline by the stimulus process. Follows KEYSCHED_SBOX_PIPE_EN if defined.
// -----------------------------------------------------------------------------
module tb_aes_key_expansion_ctrl;

`ifdef KEYSCHED_SBOX_PIPE_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    localparam int LAST_EDGE = STEP * 10;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic [3:0]   rd_idx = '0;
    logic         busy, rk_valid, done, keys_ready;
    logic [3:0]   rk_round;
    logic [127:0] rk_out, rd_key;

    aes_key_expansion_ctrl #(.NROUNDS(10)) dut (
        .clk(clk), .reset(reset), .start(start), .key_in(key_in),
        .busy(busy), .rk_valid(rk_valid), .rk_round(rk_round), .rk_out(rk_out),
        .done(done), .keys_ready(keys_ready), .rd_idx(rd_idx), .rd_key(rd_key)
    );

    always #5 clk = ~clk;

    // FIPS-197 Appendix A.1 schedule for key 2b7e1516 28aed2a6 abf71588 09cf4f3c.
    logic [127:0] fips [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    typedef struct {
        logic [3:0]   round;
        logic [127:0] key;
        bit           chk;
        bit           last;
    } exp_t;

    exp_t sb [$];
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Queue the expected stream for one run, rounds 0..upto.
    task automatic push_run(input bit zero_key, input int upto);
        exp_t e;
        for (int r = 0; r <= upto; r++) begin
            e.round = 4'(r);
            e.last  = (r == 10);
            if (!zero_key) begin
                e.key = fips[r];
                e.chk = 1'b1;
            end else begin
                e.key = (r == 1) ? ZERO_R1 : (r == 10) ? ZERO_R10 : '0;
                e.chk = (r == 0) || (r == 1) || (r == 10);
            end
            sb.push_back(e);
        end
    endtask

    // Monitor: every rk_valid cycle consumes exactly one scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (rk_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected rk_valid round", rk_round, 4'hf);
                end else begin
                    e = sb.pop_front();
                    check("rk_round", rk_round, e.round);
                    if (e.chk) check("rk_out", rk_out, e.key);
                    check("done with round", done, e.last);
                end
            end else if (done) begin
                check("done without rk_valid", done, 1'b0);
            end
        end
    end

    // Raise start before an edge and drop it #1 after that edge (E0).
    task automatic start_run();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 200);
        check("idle timeout busy", busy, 1'b0);
    endtask

    initial begin
        int busy_cycles;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset busy", busy, 1'b0);
        check("reset rk_valid", rk_valid, 1'b0);
        check("reset keys_ready", keys_ready, 1'b0);
        check("reset rk_out", rk_out, '0);
        check("reset rd_key", rd_key, '0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // FIPS key with cycle-level timing and an ignored mid-run start
        key_in = fips[0];
        push_run(1'b0, 10);
        start_run();
        busy_cycles = busy ? 1 : 0;
        check("E0 rk_round", rk_round, 4'd0);
        check("E0 keys_ready", keys_ready, 1'b0);
        for (int cyc = 1; cyc <= LAST_EDGE; cyc++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cycles++;
            if (cyc == 4) start = 1'b1;
            if (cyc == 5) start = 1'b0;
            check("rk_valid cadence", rk_valid, (cyc % STEP) == 0);
            if (cyc == LAST_EDGE) check("done at last edge", done, 1'b1);
            else check("done early", done, 1'b0);
        end
        @(posedge clk);
        #1;
        check("busy cycles", 128'(busy_cycles), 128'(LAST_EDGE + 1));
        check("post busy", busy, 1'b0);
        check("post done", done, 1'b0);
        check("post rk_valid", rk_valid, 1'b0);
        check("post keys_ready", keys_ready, 1'b1);

        // Table sweep 0..15
        for (int i = 0; i < 16; i++) begin
            rd_idx = 4'(i);
            #1;
            check($sformatf("rd_key[%0d]", i), rd_key, (i <= 10) ? fips[i] : '0);
        end

        // start held high: second run accepted on the closing edge
        push_run(1'b0, 10);
        push_run(1'b0, 10);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int cyc = 1; cyc <= LAST_EDGE + 1; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == LAST_EDGE) check("held done", done, 1'b1);
        end
        check("b2b rk_round", rk_round, 4'd0);
        check("b2b busy", busy, 1'b1);
        check("b2b rk_valid", rk_valid, 1'b1);
        check("b2b keys_ready", keys_ready, 1'b0);
        start = 1'b0;
        wait_idle();
        check("b2b scoreboard drained", 128'(sb.size()), '0);
        check("b2b keys_ready end", keys_ready, 1'b1);

        // Reset at E0+5
        push_run(1'b0, 5);
        start_run();
        for (int cyc = 1; cyc <= STEP * 5; cyc++) @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("mid reset busy", busy, 1'b0);
        check("mid reset rk_valid", rk_valid, 1'b0);
        check("mid reset done", done, 1'b0);
        check("mid reset keys_ready", keys_ready, 1'b0);
        check("mid reset rk_round", rk_round, '0);
        check("mid reset rk_out", rk_out, '0);
        for (int i = 0; i <= 10; i++) begin
            rd_idx = 4'(i);
            #1;
            check($sformatf("mid reset rd_key[%0d]", i), rd_key, '0);
        end
        check("mid reset scoreboard", 128'(sb.size()), '0);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();

        // Fresh run after reset
        push_run(1'b0, 10);
        start_run();
        wait_idle();
        check("fresh scoreboard drained", 128'(sb.size()), '0);
        check("fresh keys_ready", keys_ready, 1'b1);
        rd_idx = 4'd10;
        #1;
        check("fresh rd_key[10]", rd_key, fips[10]);

        // All-zero key
        key_in = '0;
        push_run(1'b1, 10);
        start_run();
        wait_idle();
        check("zero scoreboard drained", 128'(sb.size()), '0);
        rd_idx = 4'd1;
        #1;
        check("zero rd_key[1]", rd_key, ZERO_R1);
        rd_idx = 4'd10;
        #1;
        check("zero rd_key[10]", rd_key, ZERO_R10);
        rd_idx = 4'd11;
        #1;
        check("zero rd_key[11]", rd_key, '0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
